sw2_serial_adder: RTL and testbench
===================================

# sw2_serial_adder

Bit-serial ripple adder that sits directly downstream of the SW2 half-adder cell and consumes its sum/carry outputs. Each clock it pushes one operand bit pair plus the stored carry through two half-adder instances and an OR gate, which forms a full adder, and then latches the carry-out. It adds two WIDTH-bit operands in WIDTH cycles using a start/busy/done handshake. This is the first clocked stage in the SW2 adder series and replaces the free-running stimulus generator as the producer of multi-bit results.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits (≥2).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request. Sampled only in IDLE or DONE.
- a  in  WIDTH  operand A. Captured on the accepting edge.
- b  in  WIDTH  operand B. Captured on the accepting edge.
- cin  in  1  carry-in. Captured on the accepting edge.
- busy  out  1  high while state = RUN.
- done  out  1  one-cycle pulse, high while state = DONE.
- sum  out  WIDTH  registered result; holds its value between operations.
- cout  out  1  registered carry-out; holds its value between operations.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Internal registers:
  - sa, sb: WIDTH-bit shift registers holding the operands.
  - c: 1-bit carry.
  - acc: WIDTH-bit result shift register.
  - cnt: bit counter, ceil(log2(WIDTH+1)) bits.
- Bit datapath, built from two SW2 half-adder instances plus OR:
  - h1 = HA(sa[0], sb[0])
  - h2 = HA(h1.sum, c)
  - bit = h2.sum
  - cnext = h1.carry | h2.carry
- IDLE, start=1: load sa←a, sb←b, c←cin, cnt←0, then go to RUN. With start=0, stay in IDLE.
- RUN, every edge:
  - acc ← {bit, acc[WIDTH-1:1]}, so bit i ends at acc[i] after WIDTH shifts.
  - sa, sb shift right by 1, zero-filled.
  - c ← cnext; cnt ← cnt+1.
  - On the edge where cnt = WIDTH-1:
    - sum ← {bit, acc[WIDTH-1:1]}
    - cout ← cnext
    - go to DONE.
- DONE, start=1: reload exactly as from IDLE and go to RUN (back-to-back operation, no IDLE cycle).
- DONE, start=0: go to IDLE.
- start is ignored during RUN. Operands, cin and the running computation are unaffected.
- a, b and cin are don't-care except on the accepting edge.
- Arithmetic: {cout, sum} = a + b + cin, exact and modulo 2^(WIDTH+1). No overflow flag.
- sum and cout change only on the edge that enters DONE. During RUN they keep the previous result.

## Timing
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state = IDLE
  - busy = 0, done = 0
  - sum = 0, cout = 0
  - sa, sb, c, acc, cnt all 0
- Reset asserted mid-RUN or in DONE aborts the operation. No done pulse is issued. Outputs return to their reset values.
- Release of rst_n is synchronous to clk by the system. The first start is accepted on the first rising edge with rst_n=1.
- Latency: start accepted at edge E0, then:
  - busy = 1 from after E0 through edge E_WIDTH.
  - done = 1 for exactly one cycle after E_WIDTH.
  - sum and cout are valid from E_WIDTH onward.
  - Total: WIDTH+1 edges from the accepting edge to the done pulse.
- Throughput, back-to-back: one result every WIDTH+1 cycles (start held high or re-asserted in DONE).
- busy and done are never high together.
- done never stays high two consecutive cycles, except across a DONE→RUN→…→DONE sequence.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset values: assert rst_n=0 mid-cycle with no clock edge → busy=0, done=0, sum=0x00, cout=0 immediately.
- Basic add, WIDTH=8: a=0x3C, b=0x21, cin=0, start pulsed at E0 → busy high for 8 cycles, done pulse after E8, sum=0x5D, cout=0. The previous sum is held during RUN.
- Full carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 → sum=0x01, cout=0.
- Start ignored during RUN: accept a=0x10, b=0x20; toggle start with a=0xFF, b=0xFF at E3 and E5 → result still sum=0x30, cout=0, and done after E8 only.
- Back-to-back: hold start=1 with a=0x80, b=0x80, cin=0 and then a=0x01, b=0x02, cin=0 → first done gives sum=0x00, cout=1. RUN restarts directly from DONE. Second done arrives 9 cycles later with sum=0x03, cout=0.
- Reset mid-operation: accept a=0x55, b=0x55, assert rst_n=0 at E4 → no done pulse, outputs zero. After release, a=0x01, b=0x01 completes with sum=0x02.

Source files
------------

// File: rtl/sw2_serial_adder.sv
// Bit-serial adder: one full-adder step per clock, built from two half-adder
// cells and an OR, with a start/busy/done handshake around WIDTH shift steps.

module sw2_ha_cell (
   input  logic x,
   input  logic y,
   output logic s,
   output logic co
);
   assign s  = x ^ y;
   assign co = x & y;
endmodule

module sw2_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q, sb_q, acc_q, sum_q;
   logic [CW-1:0]    cnt_q;
   logic             c_q, cout_q, busy_q, done_q;

   logic             h1_s, h1_c, h2_s, h2_c;
   logic             bit_d, c_d;
   logic [WIDTH-1:0] acc_d;

   sw2_ha_cell u_h1 (.x(sa_q[0]), .y(sb_q[0]), .s(h1_s), .co(h1_c));
   sw2_ha_cell u_h2 (.x(h1_s),    .y(c_q),     .s(h2_s), .co(h2_c));

   assign bit_d = h2_s;
   assign c_d   = h1_c | h2_c;
   // LSB-first results enter at the top, so bit i lands at acc[i] after WIDTH shifts
   assign acc_d = {bit_d, acc_q[WIDTH-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  c_q     <= cin;
                  cnt_q   <= '0;
                  state_q <= RUN;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               acc_q <= acc_d;
               sa_q  <= {1'b0, sa_q[WIDTH-1:1]};
               sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
               c_q   <= c_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  sum_q   <= acc_d;
                  cout_q  <= c_d;
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
endmodule

// File: tb/tb_sw2_serial_adder.sv
// Self-checking bench for sw2_serial_adder: directed and random additions
// compared against plain integer arithmetic, with handshake timing checks.

module tb_sw2_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         cin = 1'b0;
   logic         busy, done, cout;
   logic [W-1:0] sum;

   int checks = 0;
   int failures = 0;

   logic [W-1:0] prev_sum = '0;
   logic         prev_cout = 1'b0;

   sw2_serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT in IDLE or DONE. Returns at the negedge
   // that shows the done pulse. With noisy set, start/a/b/cin are scrambled
   // during RUN, which must not disturb the result.
   task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                     input bit noisy, input string tag);
      logic [W:0] expv;
      expv = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
      a = ta; b = tb_; cin = tc; start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
         start = noisy ? 1'($urandom) : 1'b0;
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
         if (i == 0 || i == W - 1) begin
            check({tag, "_held_sum"}, 32'(sum), 32'(prev_sum));
            check({tag, "_held_cout"}, 32'(cout), 32'(prev_cout));
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
      check({tag, "_sum"}, 32'(sum), 32'(expv[W-1:0]));
      check({tag, "_cout"}, 32'(cout), 32'(expv[W]));
      $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d (exp %02h %0d)",
               tag, ta, tb_, tc, sum, cout, expv[W-1:0], expv[W]);
      prev_sum = expv[W-1:0];
      prev_cout = expv[W];
   endtask

   task automatic idle_cycle(input string tag);
      start = 1'b0;
      @(negedge clk);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_done"}, 32'(done), 32'd0);
      check({tag, "_idle_sum"}, 32'(sum), 32'(prev_sum));
   endtask

   initial begin
      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      op(8'h3C, 8'h21, 1'b0, 1'b0, "basic");
      idle_cycle("basic");
      op(8'hFF, 8'h01, 1'b0, 1'b0, "ripple1");
      idle_cycle("ripple1");
      op(8'hA5, 8'h5A, 1'b1, 1'b0, "ripple2");
      idle_cycle("ripple2");
      op(8'h00, 8'h00, 1'b1, 1'b0, "ripple3");
      idle_cycle("ripple3");
      op(8'h10, 8'h20, 1'b0, 1'b1, "ignore_start");
      idle_cycle("ignore_start");

      // Back-to-back: second op starts from DONE without an IDLE cycle
      op(8'h80, 8'h80, 1'b0, 1'b0, "b2b1");
      op(8'h01, 8'h02, 1'b0, 1'b0, "b2b2");
      idle_cycle("b2b2");

      // Random operations, some back-to-back, some with noise during RUN
      for (int n = 0; n < 24; n++) begin
         op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", n));
         if ($urandom_range(1, 0) == 1) idle_cycle($sformatf("rnd%0d", n));
      end

      // Reset mid-operation: sum currently holds a prior result
      op(8'h7F, 8'h01, 1'b0, 1'b0, "pre_rst");
      a = 8'h55; b = 8'h55; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      prev_sum = '0;
      prev_cout = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         check("midrst_hold_done", 32'(done), 32'd0);
      end
      rst_n = 1'b1;
      idle_cycle("post_rst");
      op(8'h01, 8'h01, 1'b0, 1'b0, "post_rst");
      idle_cycle("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
